dbus_axil_master: RTL and testbench

Data-bus master that sits directly downstream of the load/store unit in the NPC core. It converts the LSU's single-cycle data-bus request (address, write flag, write data, byte strobes) into AXI4-Lite read or write transactions, holds the pipeline while a transaction is outstanding, and returns the full 32-bit read word. The LSU then performs byte and halfword extraction.

---
 rtl/dbus_axil_master.sv | 146 ++++++++++++++
 tb/tb_dbus_axil_master.sv | 288 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/dbus_axil_master.sv
// dbus_axil_master: LSU data-bus to AXI4-Lite master, one outstanding access at a time.
// Optional DBUS_RESP_CHECK_EN reports non-OKAY responses on dbus_err_o and records err_addr.
module dbus_axil_master (
  input  logic        clk,
  input  logic        rst,
  input  logic        dbus_req_i,
  input  logic        dbus_we_i,
  input  logic [31:0] dbus_addr_i,
  input  logic [31:0] dbus_wdata_i,
  input  logic [3:0]  dbus_sel_i,
  output logic [31:0] dbus_rdata_o,
  output logic        dbus_ack_o,
  output logic        dbus_err_o,
  output logic        stall_o,
  output logic        m_awvalid,
  input  logic        m_awready,
  output logic [31:0] m_awaddr,
  output logic [2:0]  m_awprot,
  output logic        m_wvalid,
  input  logic        m_wready,
  output logic [31:0] m_wdata,
  output logic [3:0]  m_wstrb,
  input  logic        m_bvalid,
  output logic        m_bready,
  input  logic [1:0]  m_bresp,
  output logic        m_arvalid,
  input  logic        m_arready,
  output logic [31:0] m_araddr,
  output logic [2:0]  m_arprot,
  input  logic        m_rvalid,
  output logic        m_rready,
  input  logic [31:0] m_rdata,
  input  logic [1:0]  m_rresp
);
  typedef enum logic [2:0] {IDLE, RD_ADDR, RD_DATA, WR_REQ, WR_RESP, DONE} state_t;
  state_t      state_q;
  logic [31:0] addr_q, wdata_q, rdata_q;
  logic [3:0]  sel_q;
  logic        awvalid_q, wvalid_q, bready_q, arvalid_q, rready_q, ack_q;
  logic        aw_done_q, w_done_q, aw_done_d, w_done_d;
  logic        unused_addr_lsb;
  assign aw_done_d = aw_done_q | (awvalid_q & m_awready);
  assign w_done_d  = w_done_q | (wvalid_q & m_wready);
  assign unused_addr_lsb = ^dbus_addr_i[1:0];
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= IDLE;
      addr_q    <= '0;
      wdata_q   <= '0;
      sel_q     <= '0;
      rdata_q   <= '0;
      awvalid_q <= 1'b0;
      wvalid_q  <= 1'b0;
      bready_q  <= 1'b0;
      arvalid_q <= 1'b0;
      rready_q  <= 1'b0;
      ack_q     <= 1'b0;
      aw_done_q <= 1'b0;
      w_done_q  <= 1'b0;
    end else begin
      ack_q <= 1'b0;
      case (state_q)
        IDLE: if (dbus_req_i) begin
          addr_q  <= {dbus_addr_i[31:2], 2'b00};
          wdata_q <= dbus_wdata_i;
          sel_q   <= dbus_sel_i;
          if (!dbus_we_i) begin
            state_q   <= RD_ADDR;
            arvalid_q <= 1'b1;
          end else if (|dbus_sel_i) begin
            state_q   <= WR_REQ;
            awvalid_q <= 1'b1;
            wvalid_q  <= 1'b1;
            aw_done_q <= 1'b0;
            w_done_q  <= 1'b0;
          end else begin
            state_q <= DONE;
            ack_q   <= 1'b1;
          end
        end
        RD_ADDR: if (m_arready) begin
          arvalid_q <= 1'b0;
          rready_q  <= 1'b1;
          state_q   <= RD_DATA;
        end
        RD_DATA: if (m_rvalid) begin
          rready_q <= 1'b0;
          rdata_q  <= m_rdata;
          ack_q    <= 1'b1;
          state_q  <= DONE;
        end
        WR_REQ: begin
          aw_done_q <= aw_done_d;
          w_done_q  <= w_done_d;
          if (m_awready) awvalid_q <= 1'b0;
          if (m_wready) wvalid_q <= 1'b0;
          if (aw_done_d & w_done_d) begin
            bready_q <= 1'b1;
            state_q  <= WR_RESP;
          end
        end
        WR_RESP: if (m_bvalid) begin
          bready_q <= 1'b0;
          ack_q    <= 1'b1;
          state_q  <= DONE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end
`ifdef DBUS_RESP_CHECK_EN
  logic        err_q, resp_err_d, unused_err_addr;
  logic [31:0] err_addr_q;
  assign resp_err_d = (state_q == RD_DATA && m_rvalid && m_rresp != 2'b00) ||
                      (state_q == WR_RESP && m_bvalid && m_bresp != 2'b00);
  assign unused_err_addr = ^err_addr_q;
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      err_q      <= 1'b0;
      err_addr_q <= '0;
    end else begin
      err_q <= resp_err_d;
      if (resp_err_d) err_addr_q <= addr_q;
    end
  end
  assign dbus_err_o = err_q;
`else
  logic unused_resp;
  assign unused_resp = ^{m_rresp, m_bresp};
  assign dbus_err_o  = 1'b0;
`endif
  assign dbus_rdata_o = rdata_q;
  assign dbus_ack_o   = ack_q;
  assign stall_o      = dbus_req_i & ~ack_q;
  assign m_awvalid    = awvalid_q;
  assign m_awaddr     = addr_q;
  assign m_awprot     = 3'b000;
  assign m_wvalid     = wvalid_q;
  assign m_wdata      = wdata_q;
  assign m_wstrb      = sel_q;
  assign m_bready     = bready_q;
  assign m_arvalid    = arvalid_q;
  assign m_araddr     = addr_q;
  assign m_arprot     = 3'b000;
  assign m_rready     = rready_q;
endmodule

// File: tb/tb_dbus_axil_master.sv
// tb_dbus_axil_master: directed cycle-by-cycle bench driving a hand-scripted AXI4-Lite slave.
module tb_dbus_axil_master;
  logic        clk = 1'b0, rst;
  logic        dbus_req_i, dbus_we_i;
  logic [31:0] dbus_addr_i, dbus_wdata_i;
  logic [3:0]  dbus_sel_i;
  logic [31:0] dbus_rdata_o;
  logic        dbus_ack_o, dbus_err_o, stall_o;
  logic        m_awvalid, m_awready, m_wvalid, m_wready, m_bvalid, m_bready;
  logic        m_arvalid, m_arready, m_rvalid, m_rready;
  logic [31:0] m_awaddr, m_wdata, m_araddr, m_rdata;
  logic [2:0]  m_awprot, m_arprot;
  logic [3:0]  m_wstrb;
  logic [1:0]  m_bresp, m_rresp;
  int tests = 0, fails = 0;
  int ack_cnt = 0, aw_hs = 0, b_hs = 0, wv_cyc = 0;

  dbus_axil_master dut (
    .clk(clk), .rst(rst),
    .dbus_req_i(dbus_req_i), .dbus_we_i(dbus_we_i), .dbus_addr_i(dbus_addr_i),
    .dbus_wdata_i(dbus_wdata_i), .dbus_sel_i(dbus_sel_i),
    .dbus_rdata_o(dbus_rdata_o), .dbus_ack_o(dbus_ack_o), .dbus_err_o(dbus_err_o), .stall_o(stall_o),
    .m_awvalid(m_awvalid), .m_awready(m_awready), .m_awaddr(m_awaddr), .m_awprot(m_awprot),
    .m_wvalid(m_wvalid), .m_wready(m_wready), .m_wdata(m_wdata), .m_wstrb(m_wstrb),
    .m_bvalid(m_bvalid), .m_bready(m_bready), .m_bresp(m_bresp),
    .m_arvalid(m_arvalid), .m_arready(m_arready), .m_araddr(m_araddr), .m_arprot(m_arprot),
    .m_rvalid(m_rvalid), .m_rready(m_rready), .m_rdata(m_rdata), .m_rresp(m_rresp)
  );

  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (dbus_ack_o) ack_cnt++;
    if (m_awvalid && m_awready) aw_hs++;
    if (m_bvalid && m_bready) b_hs++;
    if (m_awvalid || m_wvalid) wv_cyc++;
  end

  task automatic tick;
    @(posedge clk);
    #2;
  endtask

  task automatic idle_slave;
    m_awready = 1'b0; m_wready = 1'b0; m_bvalid = 1'b0; m_bresp = 2'b00;
    m_arready = 1'b0; m_rvalid = 1'b0; m_rdata = 32'h0; m_rresp = 2'b00;
  endtask

  task automatic start_req(input logic we, input logic [31:0] addr, input logic [31:0] wdata, input logic [3:0] sel);
    dbus_req_i = 1'b1; dbus_we_i = we; dbus_addr_i = addr; dbus_wdata_i = wdata; dbus_sel_i = sel;
  endtask

  task automatic test_reset;
    rst = 1'b1;
    dbus_req_i = 1'b0; dbus_we_i = 1'b0; dbus_addr_i = 32'h0; dbus_wdata_i = 32'h0; dbus_sel_i = 4'h0;
    idle_slave();
    tick(); tick();
    tests++;
    if ({m_awvalid, m_wvalid, m_bready, m_arvalid, m_rready} !== 5'b0) begin
      fails++; $display("FAIL reset_handshake got %b want 00000", {m_awvalid, m_wvalid, m_bready, m_arvalid, m_rready});
    end
    tests++;
    if (dbus_rdata_o !== 32'h0 || dbus_ack_o !== 1'b0 || dbus_err_o !== 1'b0 || stall_o !== 1'b0) begin
      fails++; $display("FAIL reset_dbus got rdata=%h ack=%b err=%b stall=%b want 0", dbus_rdata_o, dbus_ack_o, dbus_err_o, stall_o);
    end
    tests++;
    if (m_awaddr !== 32'h0 || m_araddr !== 32'h0 || m_wdata !== 32'h0 || m_wstrb !== 4'h0 || m_awprot !== 3'h0 || m_arprot !== 3'h0) begin
      fails++; $display("FAIL reset_bus got awaddr=%h araddr=%h wdata=%h wstrb=%h want 0", m_awaddr, m_araddr, m_wdata, m_wstrb);
    end
    rst = 1'b0;
    tick();
  endtask

  task automatic test_load;
    tick();
    start_req(1'b0, 32'h8000_0006, 32'h0, 4'hF);
    #1;
    tests++;
    if (stall_o !== 1'b1) begin fails++; $display("FAIL load_stall_c0 got %b want 1", stall_o); end
    tick();
    tests++;
    if (m_arvalid !== 1'b1 || m_araddr !== 32'h8000_0004 || stall_o !== 1'b1 || dbus_ack_o !== 1'b0) begin
      fails++; $display("FAIL load_c1 got arvalid=%b araddr=%h stall=%b ack=%b want 1 80000004 1 0", m_arvalid, m_araddr, stall_o, dbus_ack_o);
    end
    m_arready = 1'b1;
    tick();
    tests++;
    if (m_arvalid !== 1'b0 || m_rready !== 1'b1 || stall_o !== 1'b1 || dbus_ack_o !== 1'b0) begin
      fails++; $display("FAIL load_c2 got arvalid=%b rready=%b stall=%b ack=%b want 0 1 1 0", m_arvalid, m_rready, stall_o, dbus_ack_o);
    end
    m_arready = 1'b0; m_rvalid = 1'b1; m_rdata = 32'h1122_3344;
    tick();
    tests++;
    if (dbus_ack_o !== 1'b1 || dbus_rdata_o !== 32'h1122_3344 || stall_o !== 1'b0 || dbus_err_o !== 1'b0) begin
      fails++; $display("FAIL load_c3 got ack=%b rdata=%h stall=%b err=%b want 1 11223344 0 0", dbus_ack_o, dbus_rdata_o, stall_o, dbus_err_o);
    end
    idle_slave();
    dbus_req_i = 1'b0;
    tick();
    tests++;
    if (dbus_ack_o !== 1'b0 || m_arvalid !== 1'b0) begin
      fails++; $display("FAIL load_after got ack=%b arvalid=%b want 0 0", dbus_ack_o, m_arvalid);
    end
  endtask

  task automatic test_store_aw_first;
    int ack0, aw0, b0;
    ack0 = ack_cnt; aw0 = aw_hs; b0 = b_hs;
    tick();
    start_req(1'b1, 32'h1000_000A, 32'hABCD_0000, 4'b1100);
    tick();
    tests++;
    if (m_awvalid !== 1'b1 || m_wvalid !== 1'b1 || m_wstrb !== 4'b1100 || m_wdata !== 32'hABCD_0000 || m_awaddr !== 32'h1000_0008) begin
      fails++; $display("FAIL store_c1 got awv=%b wv=%b wstrb=%b wdata=%h awaddr=%h want 1 1 1100 abcd0000 10000008",
                        m_awvalid, m_wvalid, m_wstrb, m_wdata, m_awaddr);
    end
    m_awready = 1'b1;
    for (int c = 2; c <= 4; c++) begin
      tick();
      m_awready = 1'b0;
      m_wready  = (c == 4);
      tests++;
      if (m_awvalid !== 1'b0 || m_wvalid !== 1'b1 || m_bready !== 1'b0 || dbus_ack_o !== 1'b0) begin
        fails++; $display("FAIL store_wait_c%0d got awv=%b wv=%b bready=%b ack=%b want 0 1 0 0", c, m_awvalid, m_wvalid, m_bready, dbus_ack_o);
      end
    end
    tick();
    tests++;
    if (m_wvalid !== 1'b0 || m_bready !== 1'b1 || m_awvalid !== 1'b0) begin
      fails++; $display("FAIL store_c5 got wv=%b bready=%b awv=%b want 0 1 0", m_wvalid, m_bready, m_awvalid);
    end
    m_wready = 1'b0; m_bvalid = 1'b1;
    tick();
    tests++;
    if (dbus_ack_o !== 1'b1 || m_bready !== 1'b0 || dbus_rdata_o !== 32'h1122_3344) begin
      fails++; $display("FAIL store_c6 got ack=%b bready=%b rdata=%h want 1 0 11223344", dbus_ack_o, m_bready, dbus_rdata_o);
    end
    idle_slave();
    dbus_req_i = 1'b0;
    tick(); tick();
    tests++;
    if (ack_cnt - ack0 != 1 || aw_hs - aw0 != 1 || b_hs - b0 != 1) begin
      fails++; $display("FAIL store_counts got ack=%0d aw=%0d b=%0d want 1 1 1", ack_cnt - ack0, aw_hs - aw0, b_hs - b0);
    end
  endtask

  task automatic test_store_nosel;
    int wv0;
    wv0 = wv_cyc;
    tick();
    start_req(1'b1, 32'h1000_0010, 32'h5555_5555, 4'b0000);
    tick();
    tests++;
    if (dbus_ack_o !== 1'b1 || dbus_err_o !== 1'b0) begin
      fails++; $display("FAIL nosel_ack got ack=%b err=%b want 1 0", dbus_ack_o, dbus_err_o);
    end
    dbus_req_i = 1'b0;
    tick(); tick();
    tests++;
    if (wv_cyc != wv0 || dbus_ack_o !== 1'b0) begin
      fails++; $display("FAIL nosel_bus got valid_cycles=%0d ack=%b want 0 0", wv_cyc - wv0, dbus_ack_o);
    end
  endtask

  task automatic test_back_pressure;
    tick();
    start_req(1'b0, 32'h2000_0010, 32'h0, 4'hF);
    for (int c = 1; c <= 9; c++) begin
      tick();
      m_arready = (c == 5);
      m_rvalid  = (c == 9);
      m_rdata   = (c == 9) ? 32'hCAFE_F00D : 32'h0;
      if (c == 2) begin
        dbus_addr_i = 32'hFFFF_FFF0; dbus_we_i = 1'b1; dbus_wdata_i = 32'h1234_5678; dbus_sel_i = 4'hF;
      end
      tests++;
      if (dbus_ack_o !== 1'b0 || m_awvalid !== 1'b0) begin
        fails++; $display("FAIL bp_c%0d got ack=%b awv=%b want 0 0", c, dbus_ack_o, m_awvalid);
      end
      if (c <= 5) begin
        tests++;
        if (m_arvalid !== 1'b1 || m_araddr !== 32'h2000_0010) begin
          fails++; $display("FAIL bp_ar_c%0d got arvalid=%b araddr=%h want 1 20000010", c, m_arvalid, m_araddr);
        end
      end else begin
        tests++;
        if (m_arvalid !== 1'b0 || m_rready !== 1'b1) begin
          fails++; $display("FAIL bp_r_c%0d got arvalid=%b rready=%b want 0 1", c, m_arvalid, m_rready);
        end
      end
    end
    tick();
    tests++;
    if (dbus_ack_o !== 1'b1 || dbus_rdata_o !== 32'hCAFE_F00D) begin
      fails++; $display("FAIL bp_c10 got ack=%b rdata=%h want 1 cafef00d", dbus_ack_o, dbus_rdata_o);
    end
    idle_slave();
    dbus_req_i = 1'b0;
    tick();
  endtask

  task automatic test_reset_mid_read;
    int ack0;
    ack0 = ack_cnt;
    tick();
    start_req(1'b0, 32'h4000_0000, 32'h0, 4'hF);
    tick();
    m_arready = 1'b1;
    tick();
    m_arready = 1'b0;
    #1 rst = 1'b1;
    #1;
    tests++;
    if (m_arvalid !== 1'b0 || m_rready !== 1'b0 || dbus_ack_o !== 1'b0 || dut.state_q !== 3'd0) begin
      fails++; $display("FAIL rst_mid got arvalid=%b rready=%b ack=%b state=%0d want 0 0 0 0", m_arvalid, m_rready, dbus_ack_o, dut.state_q);
    end
    dbus_req_i = 1'b0;
    tick();
    rst = 1'b0;
    tick(); tick();
    tests++;
    if (ack_cnt != ack0 || m_arvalid !== 1'b0) begin
      fails++; $display("FAIL rst_noack got acks=%0d arvalid=%b want 0 0", ack_cnt - ack0, m_arvalid);
    end
    start_req(1'b0, 32'h4000_0008, 32'h0, 4'hF);
    tick();
    tests++;
    if (m_arvalid !== 1'b1 || m_araddr !== 32'h4000_0008) begin
      fails++; $display("FAIL rst_next_ar got arvalid=%b araddr=%h want 1 40000008", m_arvalid, m_araddr);
    end
    m_arready = 1'b1;
    tick();
    m_arready = 1'b0; m_rvalid = 1'b1; m_rdata = 32'h55AA_55AA;
    tick();
    tests++;
    if (dbus_ack_o !== 1'b1 || dbus_rdata_o !== 32'h55AA_55AA) begin
      fails++; $display("FAIL rst_next_ack got ack=%b rdata=%h want 1 55aa55aa", dbus_ack_o, dbus_rdata_o);
    end
    idle_slave();
    dbus_req_i = 1'b0;
    tick();
  endtask

  task automatic test_resp_error;
    logic exp_err;
`ifdef DBUS_RESP_CHECK_EN
    exp_err = 1'b1;
`else
    exp_err = 1'b0;
`endif
    tick();
    start_req(1'b0, 32'h3000_000E, 32'h0, 4'hF);
    tick();
    m_arready = 1'b1;
    tick();
    m_arready = 1'b0; m_rvalid = 1'b1; m_rdata = 32'hDEAD_BEEF; m_rresp = 2'b10;
    tick();
    tests++;
    if (dbus_ack_o !== 1'b1 || dbus_err_o !== exp_err || dbus_rdata_o !== 32'hDEAD_BEEF) begin
      fails++; $display("FAIL err_c3 got ack=%b err=%b rdata=%h want 1 %b deadbeef", dbus_ack_o, dbus_err_o, dbus_rdata_o, exp_err);
    end
`ifdef DBUS_RESP_CHECK_EN
    tests++;
    if (dut.err_addr_q !== 32'h3000_000C) begin
      fails++; $display("FAIL err_addr got %h want 3000000c", dut.err_addr_q);
    end
`endif
    idle_slave();
    dbus_req_i = 1'b0;
    tick();
    tests++;
    if (dbus_err_o !== 1'b0 || dbus_ack_o !== 1'b0) begin
      fails++; $display("FAIL err_clear got err=%b ack=%b want 0 0", dbus_err_o, dbus_ack_o);
    end
  endtask

  initial begin
    test_reset();
    test_load();
    test_store_aw_first();
    test_store_nosel();
    test_back_pressure();
    test_reset_mid_read();
    test_resp_error();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
